// File: rtl/dac_spi_arbiter.sv
// rtl/dac_spi_arbiter.sv - round-robin arbiter sharing one DAC SPI link between wave and ctrl sources
// Grants in IDLE, shifts {CFG, data} MSB first over 16 SCLK periods, then holds CSB high.
module dac_spi_arbiter #(
  parameter int          SCLK_HALF = 4,
  parameter int          CS_HIGH   = 4,
  parameter logic [3:0]  CFG       = 4'b0011
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wave_req,
  input  logic [11:0] wave_data,
  output logic        wave_ack,
  input  logic        ctrl_req,
  input  logic [11:0] ctrl_data,
  output logic        ctrl_ack,
  input  logic        mute,
  output logic        DAC_CSB,
  output logic        DAC_SCLK,
  output logic        DAC_DIN,
  output logic        busy,
  output logic        frame_done,
  output logic        last_src
);

  localparam int PMAX = (SCLK_HALF > CS_HIGH) ? SCLK_HALF : CS_HIGH;
  localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(CS_HIGH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [15:0]     shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic            phase_hi_q, phase_hi_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_src_q, last_src_d;
  logic            grant_wave, grant_ctrl;

  // On a tie the source that did not win last time is served.
  assign grant_wave = wave_req & (~ctrl_req | last_src_q);
  assign grant_ctrl = ctrl_req & (~wave_req | ~last_src_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      phase_hi_q <= 1'b0;
      cnt_q      <= '0;
      last_src_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      phase_hi_q <= phase_hi_d;
      cnt_q      <= cnt_d;
      last_src_q <= last_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    phase_hi_d = phase_hi_q;
    cnt_d      = cnt_q;
    last_src_d = last_src_q;
    wave_ack   = 1'b0;
    ctrl_ack   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        // reset_n gating keeps the combinational acks quiet while reset is held.
        if (reset_n && (grant_ctrl || grant_wave)) begin
          if (grant_ctrl) begin
            ctrl_ack   = 1'b1;
            shift_d    = {CFG, ctrl_data};
            last_src_d = 1'b1;
          end else begin
            wave_ack   = 1'b1;
            shift_d    = {CFG, mute ? 12'h800 : wave_data};
            last_src_d = 1'b0;
          end
          bit_d      = 4'd15;
          phase_hi_d = 1'b0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!phase_hi_q) begin
            phase_hi_d = 1'b1;
          end else begin
            phase_hi_d = 1'b0;
            if (bit_q == 4'd0) state_d = HOLD;
            else               bit_d   = bit_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          frame_done = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE) | wave_ack | ctrl_ack;
  assign DAC_CSB  = (state_q != SHIFT);
  assign DAC_SCLK = (state_q == SHIFT) & phase_hi_q;
  assign DAC_DIN  = (state_q == SHIFT) & shift_q[bit_q];
  assign last_src = last_src_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// tb/tb_dac_spi_arbiter.sv - directed self-checking bench for dac_spi_arbiter
// Instance u0 uses default timing, u1 uses SCLK_HALF=1, CS_HIGH=1.
module tb_dac_spi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        wave_req0, ctrl_req0, mute0, wave_req1, ctrl_req1, mute1;
  logic [11:0] wave_data0, ctrl_data0, wave_data1, ctrl_data1;
  logic        wave_ack0, ctrl_ack0, csb0, sclk0, din0, busy0, done0, last0;
  logic        wave_ack1, ctrl_ack1, csb1, sclk1, din1, busy1, done1, last1;

  dac_spi_arbiter u0 (
    .clk(clk), .reset_n(reset_n),
    .wave_req(wave_req0), .wave_data(wave_data0), .wave_ack(wave_ack0),
    .ctrl_req(ctrl_req0), .ctrl_data(ctrl_data0), .ctrl_ack(ctrl_ack0),
    .mute(mute0), .DAC_CSB(csb0), .DAC_SCLK(sclk0), .DAC_DIN(din0),
    .busy(busy0), .frame_done(done0), .last_src(last0)
  );

  dac_spi_arbiter #(.SCLK_HALF(1), .CS_HIGH(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .wave_req(wave_req1), .wave_data(wave_data1), .wave_ack(wave_ack1),
    .ctrl_req(ctrl_req1), .ctrl_data(ctrl_data1), .ctrl_ack(ctrl_ack1),
    .mute(mute1), .DAC_CSB(csb1), .DAC_SCLK(sclk1), .DAC_DIN(din1),
    .busy(busy1), .frame_done(done1), .last_src(last1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI receivers: capture DIN on each SCLK rise, count CSB-low cycles, flag DIN moving while SCLK high.
  int          rises0 = 0, csbl0 = 0, dinbad0 = 0, rises1 = 0, csbl1 = 0, dinbad1 = 0;
  logic [15:0] frm0 = '0, frm1 = '0;
  logic        sp0 = 1'b0, dl0 = 1'b0, sp1 = 1'b0, dl1 = 1'b0;

  always @(negedge clk) begin
    if (!csb0) csbl0 <= csbl0 + 1;
    if (sclk0 && !sp0) begin
      rises0 <= rises0 + 1;
      frm0   <= {frm0[14:0], din0};
    end
    if (sclk0 && !csb0 && din0 !== dl0) dinbad0 <= dinbad0 + 1;
    if (!sclk0) dl0 <= din0;
    sp0 <= sclk0;
  end

  always @(negedge clk) begin
    if (!csb1) csbl1 <= csbl1 + 1;
    if (sclk1 && !sp1) begin
      rises1 <= rises1 + 1;
      frm1   <= {frm1[14:0], din1};
    end
    if (sclk1 && !csb1 && din1 !== dl1) dinbad1 <= dinbad1 + 1;
    if (!sclk1) dl1 <= din1;
    sp1 <= sclk1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack0(output int t, output logic w, output logic c);
    t = -1; w = 1'b0; c = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (wave_ack0 || ctrl_ack0) begin
        t = cyc; w = wave_ack0; c = ctrl_ack0;
        return;
      end
    end
    chk("ack0_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_ack1(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (wave_ack1) begin
        t = cyc;
        return;
      end
    end
    chk("ack1_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done0(output int n, output int ca);
    n = 0; ca = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      n++;
      if (ctrl_ack0) ca++;
      if (done0) return;
    end
    chk("done0_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int t, tp, n, ca, r0, c0, r1, c1;
    logic w, c;
    logic [15:0] exp_frm [4];
    reset_n = 1'b0;
    wave_req0 = 0; ctrl_req0 = 0; mute0 = 0; wave_data0 = '0; ctrl_data0 = '0;
    wave_req1 = 0; ctrl_req1 = 0; mute1 = 0; wave_data1 = '0; ctrl_data1 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_csb", csb0, 1'b1);
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_din", din0, 1'b0);
    chk("rst_acks", {wave_ack0, ctrl_ack0, wave_ack1, ctrl_ack1}, 4'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_last", last0, 1'b0);

    // Single wave frame
    @(posedge clk); #1;
    reset_n = 1'b1; wave_data0 = 12'hA5C; wave_req0 = 1'b1;
    wait_ack0(t, w, c);
    chk("t1_src", {w, c}, 2'b10);
    chk("t1_busy_grant", busy0, 1'b1);
    r0 = rises0; c0 = csbl0;
    @(posedge clk); #1;
    wave_req0 = 1'b0;
    wait_done0(n, ca);
    chk("t1_done_lat", n, 132);
    chk("t1_rises", rises0 - r0, 16);
    chk("t1_frame", frm0, 16'h3A5C);
    chk("t1_csb_low", csbl0 - c0, 128);
    chk("t1_busy_hold", busy0, 1'b1);
    chk("t1_last", last0, 1'b0);
    @(negedge clk); #1;
    chk("t1_busy_idle", busy0, 1'b0);
    chk("t1_csb_idle", csb0, 1'b1);

    // Both requesting: alternate ctrl, wave, ctrl, wave
    @(posedge clk); #1;
    ctrl_data0 = 12'h123; wave_data0 = 12'h456; ctrl_req0 = 1; wave_req0 = 1;
    exp_frm[0] = 16'h3123; exp_frm[1] = 16'h3456; exp_frm[2] = 16'h3123; exp_frm[3] = 16'h3456;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack0(t, w, c);
      if (i > 0) begin
        chk("t2_gap", t - tp, 133);
        chk("t2_frame", frm0, exp_frm[i-1]);
      end
      chk("t2_src", {w, c}, (i % 2 == 0) ? 2'b01 : 2'b10);
      tp = t;
      @(posedge clk); #1;
      if (i == 3) begin
        ctrl_req0 = 0; wave_req0 = 0;
      end
    end
    wait_done0(n, ca);
    chk("t2_frame_last", frm0, 16'h3456);

    // Mute on a wave frame, toggled mid-shift; ctrl frame ignores mute
    @(posedge clk); #1;
    mute0 = 1; wave_data0 = 12'hFFF; wave_req0 = 1;
    wait_ack0(t, w, c);
    chk("t3_src", {w, c}, 2'b10);
    @(posedge clk); #1;
    wave_req0 = 0;
    repeat (40) @(posedge clk);
    #1 mute0 = 0;
    wait_done0(n, ca);
    chk("t3_mute_frame", frm0, 16'h3800);
    @(posedge clk); #1;
    mute0 = 1; ctrl_data0 = 12'h7E1; ctrl_req0 = 1;
    wait_ack0(t, w, c);
    chk("t3_ctrl_src", {w, c}, 2'b01);
    @(posedge clk); #1;
    ctrl_req0 = 0;
    wait_done0(n, ca);
    chk("t3_ctrl_frame", frm0, 16'h37E1);
    mute0 = 0;

    // Reset in the middle of a frame after the 7th SCLK rise
    @(posedge clk); #1;
    wave_data0 = 12'h0F0; wave_req0 = 1;
    wait_ack0(t, w, c);
    r0 = rises0;
    @(posedge clk); #1;
    wave_req0 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rises0 - r0 == 7) break;
    end
    chk("t4_rises", rises0 - r0, 7);
    chk("t4_sclk_pre", sclk0, 1'b1);
    reset_n = 0; wave_req0 = 1; ctrl_req0 = 1; ctrl_data0 = 12'h7E1;
    #1;
    chk("t4_csb", csb0, 1'b1);
    chk("t4_sclk", sclk0, 1'b0);
    chk("t4_din", din0, 1'b0);
    chk("t4_busy", busy0, 1'b0);
    chk("t4_acks", {wave_ack0, ctrl_ack0}, 2'b00);
    @(posedge clk); #1;
    reset_n = 1;
    wait_ack0(t, w, c);
    chk("t4_src", {w, c}, 2'b01);
    @(posedge clk); #1;
    wave_req0 = 0; ctrl_req0 = 0;
    wait_done0(n, ca);
    chk("t4_frame", frm0, 16'h37E1);

    // ctrl request arriving mid-frame waits for IDLE
    @(posedge clk); #1;
    wave_data0 = 12'h3C3; wave_req0 = 1;
    wait_ack0(t, w, c);
    chk("t5_src", {w, c}, 2'b10);
    @(posedge clk); #1;
    wave_req0 = 0;
    repeat (50) @(posedge clk);
    #1 ctrl_data0 = 12'h111; ctrl_req0 = 1;
    wait_done0(n, ca);
    chk("t5_no_early_ack", ca, 0);
    chk("t5_wave_frame", frm0, 16'h33C3);
    @(negedge clk); #1;
    chk("t5_ack_after_done", ctrl_ack0, 1'b1);
    @(posedge clk); #1;
    ctrl_req0 = 0;
    wait_done0(n, ca);
    chk("t5_ctrl_frame", frm0, 16'h3111);

    // Fast timing instance: SCLK_HALF=1, CS_HIGH=1
    @(posedge clk); #1;
    wave_data1 = 12'hABC; wave_req1 = 1;
    wait_ack1(tp);
    r1 = rises1; c1 = csbl1;
    @(posedge clk); #1;
    wait_ack1(t);
    chk("t6_gap", t - tp, 34);
    chk("t6_rises", rises1 - r1, 16);
    chk("t6_csb_low", csbl1 - c1, 32);
    chk("t6_frame", frm1, 16'h3ABC);
    @(posedge clk); #1;
    wave_req1 = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      n++;
      if (done1) break;
    end
    chk("t6_done_lat", n, 33);
    @(negedge clk); #1;
    chk("t6_busy_idle", {busy1, last1, ctrl_ack1}, 3'b000);
    chk("din_stable0", dinbad0, 0);
    chk("din_stable1", dinbad1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
